// File: rtl/biriscv_v_wb_pkg.sv
// -----------------------------------------------------------------------------
// biriscv_defs
// Shared definitions for the vector writeback path: VRF index and PC widths,
// element-count derivation and the queue entry width. The entry layout itself
// is {vd, pc, result, elem_en} with vd in the most significant bits. The
// writeback stage relies on this ordering when it builds its pending scoreboard.
// -----------------------------------------------------------------------------
package biriscv_defs;

  localparam int VRF_IDX_W = 5;
  localparam int PC_W      = 32;
  localparam int NUM_VREGS = 1 << VRF_IDX_W;

  // Number of ELEN-wide elements in one VLEN-wide vector register.
  function automatic int calc_nelem(input int vlen, input int elen);
    return vlen / elen;
  endfunction

  // Packed width of one queue entry {vd, pc, result, elem_en}.
  function automatic int calc_entry_w(input int vlen, input int elen);
    return VRF_IDX_W + PC_W + vlen + calc_nelem(vlen, elen);
  endfunction

endpackage

// File: rtl/biriscv_v_wb_fifo.sv
// -----------------------------------------------------------------------------
// biriscv_v_wb_fifo
// Generic DEPTH x WIDTH circular FIFO with a valid/ready handshake on both
// sides and a flush. It has no full-with-pop pass-through: in_ready_o depends
// only on the current occupancy. Besides the head, the FIFO exposes a per-slot
// occupied mask and the top TAG_W bits of every slot. A consumer can use these
// to build a scoreboard over the queued entries.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-low reset
//   flush_i             drop all entries (rd_ptr <= wr_ptr); push/pop ignored
//   in_valid_i/ready_o  enqueue handshake, in_data_i payload
//   out_valid_o/ready_i dequeue handshake, out_data_o head payload
//   occ_o[i]            slot i holds a live entry
//   tag_o[i]            top TAG_W bits of slot i
// -----------------------------------------------------------------------------
module biriscv_v_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int TAG_W = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [WIDTH-1:0]            in_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [WIDTH-1:0]            out_data_o,
  output logic [DEPTH-1:0]            occ_o,
  output logic [DEPTH-1:0][TAG_W-1:0] tag_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0] w_wr_idx, w_rd_idx;
  logic [PTR_W-1:0] w_count;
  logic             w_full, w_empty, w_push, w_pop;

  assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
  assign w_rd_idx = r_rd_ptr[IDX_W-1:0];
  assign w_count  = r_wr_ptr - r_rd_ptr;

  // The extra pointer bit separates a full queue from an empty one when the
  // slot indices are equal.
  assign w_full  = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) && (w_wr_idx == w_rd_idx);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign in_ready_o  = !w_full;
  assign out_valid_o = !w_empty;
  assign out_data_o  = r_mem[w_rd_idx];

  assign w_push = in_valid_i && !w_full && !flush_i;
  assign w_pop  = out_valid_o && out_ready_i && !flush_i;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: payload storage is deliberately not reset. Every consumer qualifies
  // it with occupancy, and leaving it unreset lets it map to plain RAM/flops
  // without a reset net.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[w_wr_idx] <= in_data_i;
  end

  // Slot g is live when its distance from the read index is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [IDX_W-1:0] w_off;
    assign w_off    = IDX_W'(g) - w_rd_idx;
    assign occ_o[g] = ({1'b0, w_off} < w_count);
    assign tag_o[g] = r_mem[g][WIDTH-1 -: TAG_W];
  end

endmodule

// File: rtl/biriscv_v_wb.sv
// -----------------------------------------------------------------------------
// biriscv_v_wb
// Vector ALU writeback stage. Results from vector execute are queued in order
// and drained into the VRF write port. An entry with no active elements retires
// without a write. Each retire produces a one-cycle completion pulse carrying
// the PC. pending_o marks every vector register targeted by a queued entry.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-low reset
//   flush_i            discard queue; no write/completion that cycle
//   exec_*             result handshake from execute (vd, pc, result, elem_en)
//   vrf_wr_*           VRF write request (en/idx/data/be) and grant (ready_i)
//   complete_o/_pc_o   retire pulse and PC of the retiring instruction
//   pending_o          destination scoreboard over queued entries
// -----------------------------------------------------------------------------
module biriscv_v_wb
  import biriscv_defs::*;
#(
  parameter int VLEN  = 128,
  parameter int ELEN  = 32,
  parameter int DEPTH = 2,
  localparam int NELEM = calc_nelem(VLEN, ELEN)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 exec_valid_i,
  output logic                 exec_ready_o,
  input  logic [VRF_IDX_W-1:0] exec_vd_idx_i,
  input  logic [PC_W-1:0]      exec_pc_i,
  input  logic [VLEN-1:0]      exec_result_i,
  input  logic [NELEM-1:0]     exec_elem_en_i,
  output logic                 vrf_wr_en_o,
  input  logic                 vrf_wr_ready_i,
  output logic [VRF_IDX_W-1:0] vrf_wr_idx_o,
  output logic [VLEN-1:0]      vrf_wr_data_o,
  output logic [NELEM-1:0]     vrf_wr_be_o,
  output logic                 complete_o,
  output logic [PC_W-1:0]      complete_pc_o,
  output logic [NUM_VREGS-1:0] pending_o
);

  localparam int ENTRY_W = calc_entry_w(VLEN, ELEN);

  // The vd field comes first, so the FIFO tag (its top bits) is the destination.
  typedef struct packed {
    logic [VRF_IDX_W-1:0] vd;
    logic [PC_W-1:0]      pc;
    logic [VLEN-1:0]      result;
    logic [NELEM-1:0]     elem_en;
  } entry_t;

  entry_t                            w_in_entry, w_head;
  logic                              w_head_valid, w_has_elem, w_retire;
  logic [DEPTH-1:0]                  w_occ;
  logic [DEPTH-1:0][VRF_IDX_W-1:0]   w_tags;

  assign w_in_entry = '{vd: exec_vd_idx_i, pc: exec_pc_i,
                        result: exec_result_i, elem_en: exec_elem_en_i};

  biriscv_v_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .TAG_W (VRF_IDX_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (exec_valid_i),
    .in_ready_o  (exec_ready_o),
    .in_data_i   (w_in_entry),
    .out_valid_o (w_head_valid),
    .out_ready_i (w_retire),
    .out_data_o  (w_head),
    .occ_o       (w_occ),
    .tag_o       (w_tags)
  );

  assign w_has_elem = |w_head.elem_en;

  // An all-masked entry leaves without waiting for the VRF port. A flush
  // suppresses both the write and the retire in the same cycle.
  assign vrf_wr_en_o = w_head_valid && w_has_elem && !flush_i;
  assign w_retire    = w_head_valid && !flush_i && (!w_has_elem || vrf_wr_ready_i);

  // Head fields are gated so that stale payload never reaches the port.
  assign vrf_wr_idx_o  = w_head_valid ? w_head.vd      : '0;
  assign vrf_wr_data_o = w_head_valid ? w_head.result  : '0;
  assign vrf_wr_be_o   = w_head_valid ? w_head.elem_en : '0;

  assign complete_o    = w_retire;
  assign complete_pc_o = w_retire ? w_head.pc : '0;

  // NOTE: the default at the top of the block covers every bit on every path,
  // so no latch is inferred.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_occ[i]) pending_o[w_tags[i]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_biriscv_v_wb.sv
// -----------------------------------------------------------------------------
// tb_biriscv_v_wb
// Self-checking bench for biriscv_v_wb. A queue of operations is the reference
// model. Every cycle, at the falling edge, the outputs are compared against the
// head of that queue and the current inputs. The queue then advances with the
// accept/retire/flush rules. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_biriscv_v_wb;

  localparam int VLEN  = 128;
  localparam int ELEN  = 32;
  localparam int NELEM = VLEN / ELEN;
  localparam int DEPTH = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              exec_valid_i;
  logic              exec_ready_o;
  logic [4:0]        exec_vd_idx_i;
  logic [31:0]       exec_pc_i;
  logic [VLEN-1:0]   exec_result_i;
  logic [NELEM-1:0]  exec_elem_en_i;
  logic              vrf_wr_en_o;
  logic              vrf_wr_ready_i;
  logic [4:0]        vrf_wr_idx_o;
  logic [VLEN-1:0]   vrf_wr_data_o;
  logic [NELEM-1:0]  vrf_wr_be_o;
  logic              complete_o;
  logic [31:0]       complete_pc_o;
  logic [31:0]       pending_o;

  biriscv_v_wb #(.VLEN(VLEN), .ELEN(ELEN), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .exec_valid_i   (exec_valid_i),
    .exec_ready_o   (exec_ready_o),
    .exec_vd_idx_i  (exec_vd_idx_i),
    .exec_pc_i      (exec_pc_i),
    .exec_result_i  (exec_result_i),
    .exec_elem_en_i (exec_elem_en_i),
    .vrf_wr_en_o    (vrf_wr_en_o),
    .vrf_wr_ready_i (vrf_wr_ready_i),
    .vrf_wr_idx_o   (vrf_wr_idx_o),
    .vrf_wr_data_o  (vrf_wr_data_o),
    .vrf_wr_be_o    (vrf_wr_be_o),
    .complete_o     (complete_o),
    .complete_pc_o  (complete_pc_o),
    .pending_o      (pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]       vd;
    logic [31:0]      pc;
    logic [VLEN-1:0]  res;
    logic [NELEM-1:0] en;
  } op_t;

  op_t model_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_writes = 0;
  int  n_completes = 0;

  task automatic check(input string tag, input logic [VLEN-1:0] got,
                       input logic [VLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs from the model queue and the present inputs.
  task automatic check_outputs();
    logic [31:0] exp_pend;
    logic        exp_wr, exp_ret;
    op_t         h;
    exp_pend = '0;
    foreach (model_q[i]) exp_pend[model_q[i].vd] = 1'b1;
    check("exec_ready", exec_ready_o, model_q.size() < DEPTH);
    check("pending", pending_o, exp_pend);
    if (model_q.size() == 0) begin
      check("wr_en_empty", vrf_wr_en_o, 0);
      check("wr_idx_empty", vrf_wr_idx_o, 0);
      check("wr_data_empty", vrf_wr_data_o, 0);
      check("wr_be_empty", vrf_wr_be_o, 0);
      check("complete_empty", complete_o, 0);
      check("cpc_empty", complete_pc_o, 0);
    end else begin
      h       = model_q[0];
      exp_wr  = (h.en != 0) && !flush_i;
      exp_ret = !flush_i && ((h.en == 0) || vrf_wr_ready_i);
      check("wr_en", vrf_wr_en_o, exp_wr);
      check("wr_idx", vrf_wr_idx_o, h.vd);
      check("wr_data", vrf_wr_data_o, h.res);
      check("wr_be", vrf_wr_be_o, h.en);
      check("complete", complete_o, exp_ret);
      check("complete_pc", complete_pc_o, exp_ret ? h.pc : 32'd0);
    end
  endtask

  // Advance the model across the coming rising edge.
  task automatic update_model();
    op_t o;
    bit  ret, acc;
    if (!rst_i || flush_i) begin
      model_q.delete();
    end else begin
      ret = (model_q.size() != 0) &&
            ((model_q[0].en == 0) || vrf_wr_ready_i);
      acc = exec_valid_i && (model_q.size() < DEPTH);
      if (ret) begin
        if (model_q[0].en != 0) n_writes++;
        n_completes++;
        void'(model_q.pop_front());
      end
      if (acc) begin
        o.vd = exec_vd_idx_i; o.pc = exec_pc_i;
        o.res = exec_result_i; o.en = exec_elem_en_i;
        model_q.push_back(o);
      end
    end
  endtask

  // Inputs are set by the caller after a rising edge and checked mid-cycle.
  task automatic cycle();
    @(negedge clk_i);
    check_outputs();
    update_model();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] vd, input logic [31:0] pc,
                       input logic [NELEM-1:0] en);
    exec_valid_i   = v;
    exec_vd_idx_i  = vd;
    exec_pc_i      = pc;
    exec_elem_en_i = en;
    exec_result_i  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; vrf_wr_ready_i = 1'b1;
    drive(0, 0, 0, 0);
    #2;
    check_outputs();
    repeat (2) cycle();
    rst_i = 1'b1;
    cycle();

    // Single op: write and complete one cycle after acceptance.
    drive(1, 5'd3, 32'h100, 4'b1111);
    exec_result_i = {32'd4, 32'd3, 32'd2, 32'd1};
    cycle();
    exec_valid_i = 0;
    repeat (2) cycle();

    // Masked and zero-enable ops.
    drive(1, 5'd9, 32'h104, 4'b0101); cycle();
    drive(1, 5'd10, 32'h108, 4'b0000); cycle();
    exec_valid_i = 0;
    repeat (2) cycle();

    // Back-pressure: three offers while the VRF port is stalled.
    vrf_wr_ready_i = 0;
    drive(1, 5'd1, 32'h200, 4'b1111); cycle();
    drive(1, 5'd2, 32'h204, 4'b0011); cycle();
    drive(1, 5'd4, 32'h208, 4'b1100); cycle(); cycle();
    vrf_wr_ready_i = 1;
    cycle(); cycle();
    exec_valid_i = 0;
    repeat (3) cycle();

    // Same-vd hazard.
    vrf_wr_ready_i = 0;
    drive(1, 5'd7, 32'h300, 4'b1111); cycle();
    drive(1, 5'd7, 32'h304, 4'b1010); cycle();
    exec_valid_i = 0;
    cycle();
    vrf_wr_ready_i = 1;
    repeat (3) cycle();

    // Flush while full, with a simultaneous offer.
    vrf_wr_ready_i = 0;
    drive(1, 5'd11, 32'h400, 4'b1111); cycle();
    drive(1, 5'd12, 32'h404, 4'b1111); cycle();
    flush_i = 1;
    drive(1, 5'd13, 32'h408, 4'b1111); cycle();
    flush_i = 0; exec_valid_i = 0; vrf_wr_ready_i = 1;
    repeat (2) cycle();

    // Async reset in the middle of a drain.
    vrf_wr_ready_i = 0;
    drive(1, 5'd20, 32'h500, 4'b1111); cycle();
    drive(1, 5'd21, 32'h504, 4'b1111); cycle();
    exec_valid_i = 0; vrf_wr_ready_i = 1;
    #2;
    rst_i = 1'b0;
    #1;
    model_q.delete();
    check("rst_wr_en", vrf_wr_en_o, 0);
    check("rst_complete", complete_o, 0);
    check("rst_pending", pending_o, 0);
    check("rst_ready", exec_ready_o, 1);
    cycle();
    rst_i = 1'b1;
    repeat (2) cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
            $urandom, ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom));
      vrf_wr_ready_i = ($urandom_range(0, 3) != 0);
      flush_i        = ($urandom_range(0, 40) == 0);
      cycle();
    end
    flush_i = 0; exec_valid_i = 0; vrf_wr_ready_i = 1;
    repeat (4) cycle();
    check("drained", pending_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/biriscv_v_wb.md
# biriscv_v_wb

Vector ALU writeback stage for the biRISC-V vector path: the consuming end of the vector execute interface. Accepts element-wise results (VLEN bits + destination index + per-element write enables) from the vector execute unit through a valid/ready handshake, buffers them in a small in-order queue and drains them into the vector register file (VRF) write port. Produces the per-instruction completion pulse the execute side lacks, plus a pending-destination scoreboard for issue hazard checks.

## Interface
- VLEN, 128, vector register width in bits
- ELEN, 32, element width in bits; NELEM = VLEN/ELEN
- DEPTH, 2, queue entries (power of two, >= 2)

- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- flush_i  in  1  pipeline flush; discards all queued entries
- exec_valid_i  in  1  result offered
- exec_ready_o  out  1  result can be accepted
- exec_vd_idx_i  in  5  destination vector register
- exec_pc_i  in  32  instruction PC
- exec_result_i  in  VLEN  element results, element i at bits [(i+1)*ELEN-1 -: ELEN]
- exec_elem_en_i  in  NELEM  element write enables (1 = active element; vm=1 gives all ones)
- vrf_wr_en_o  out  1  VRF write request
- vrf_wr_ready_i  in  1  VRF port granted this cycle
- vrf_wr_idx_o  out  5  VRF write index
- vrf_wr_data_o  out  VLEN  write data
- vrf_wr_be_o  out  NELEM  per-element write enables (inactive elements undisturbed)
- complete_o  out  1  one-cycle instruction retire pulse
- complete_pc_o  out  32  PC of retiring instruction
- pending_o  out  32  bit v set while any queued entry targets vd = v

## Operation
- Queue: DEPTH-entry circular FIFO, fields {vd, pc, result, elem_en}; wr_ptr/rd_ptr of log2(DEPTH)+1 bits, full = MSBs differ and LSBs equal, empty = pointers equal.
- Enqueue: exec_valid_i && exec_ready_o; exec_ready_o = !full (no full-with-dequeue pass-through).
- Head drive: when !empty, head fields drive vrf_wr_idx_o/data/be. vrf_wr_en_o = !empty && |head.elem_en.
- Retire: head leaves when (vrf_wr_en_o && vrf_wr_ready_i) or (!empty && head.elem_en == 0). Zero-enable entry retires with no VRF write, still completes.
- complete_o = retire condition this cycle; complete_pc_o = head.pc (0 when not retiring).
- pending_o: OR over occupied entries of onehot(vd); derived from queue state only (an entry accepted this cycle appears next cycle; a retiring entry clears next cycle).
- Flush: rd_ptr <= wr_ptr, no write, no completion that cycle; a simultaneous enqueue is dropped; flush has priority over everything.
- Simultaneous enqueue and retire: both take effect; occupancy unchanged.

## Timing
- Reset (rst_i low, async): pointers 0; exec_ready_o=1, vrf_wr_en_o=0, complete_o=0, pending_o=0, all data outputs 0 (payload storage not reset; outputs gated by !empty). Reset mid-drain loses queued entries without completion.
- Latency: accepted in cycle N -> earliest VRF write and complete_o in N+1 (empty queue, vrf_wr_ready_i=1).
- Throughput: one retire per cycle sustained with vrf_wr_ready_i held high.
- Back-pressure: vrf_wr_ready_i low holds head and outputs stable; queue fills after DEPTH accepts, exec_ready_o drops the following cycle.
- Order: strictly in-order retire; same vd in two entries keeps pending bit set until the second retires.

## Structure
- Shared package (biriscv_defs): NELEM derivation, VRF index width (5), queue entry field layout.
- One sub-module natural: biriscv_v_wb_fifo (generic DEPTH x WIDTH FIFO, valid/ready, flush); top adds retire rule, completion and scoreboard.
- Target 150-250 lines RTL.

## Test plan
- Single op: vd=3, result=128'h4_3_2_1 (per element), elem_en=4'b1111, wr_ready=1 -> N+1: vrf_wr_en_o=1, idx=3, be=1111, complete_o=1 with pc; pending_o[3] high exactly one cycle.
- Masked: elem_en=4'b0101 -> be=0101; elem_en=4'b0000 -> no vrf_wr_en_o, complete_o still pulses in N+1.
- Back-pressure: wr_ready=0, push 3 ops -> exec_ready_o low after 2 accepts, third held; release -> three writes in order on consecutive cycles, three completions.
- Same-vd hazard: two ops to vd=7 queued -> pending_o[7] stays high until second retires, then 0.
- Flush while full with simultaneous exec_valid_i -> no writes/completions, queue empty next cycle, pending_o=0, exec_ready_o=1.
- Async reset asserted mid-drain -> outputs to reset values immediately, no completion after deassert.
